// File: rtl/uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder
//
// Buffered front end for uart_tx. Bytes arrive on a back-pressured
// AXI-Stream slave, are held in a DEPTH-entry FIFO, and are handed to uart_tx
// one at a time as a single-cycle tx_tvalid pulse. The next byte is only
// offered after uart_tx reports tx_done (plus an optional idle gap). This
// lets a producer burst data without knowing anything about UART timing.
//
// Optional feature (macro UART_TX_FEEDER_TIMEOUT_EN):
//   When defined, WAIT_DONE runs a watchdog counter. If tx_done does not
//   arrive within TIMEOUT_CLKS clocks, timeout_err pulses for one cycle, the
//   byte is treated as sent, and the FSM returns to IDLE. When undefined, no
//   counter exists, WAIT_DONE waits forever and timeout_err is tied to 0.
//
// Parameters:
//   DEPTH        FIFO entries, power of two, >= 2
//   GAP_CLKS     idle clocks after tx_done before the next issue (0 = none)
//   TIMEOUT_CLKS tx_done watchdog length (only used with the macro)
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   s_axis_tdata   input byte
//   s_axis_tvalid  input byte valid
//   s_axis_tready  FIFO can accept (= !fifo_full, from registered state)
//   tx_tdata       byte presented to uart_tx, held until the next pop
//   tx_tvalid      one-cycle issue pulse to uart_tx
//   tx_busy        uart_tx busy
//   tx_done        uart_tx end-of-frame pulse
//   fifo_count     occupancy 0..DEPTH
//   fifo_empty     fifo_count == 0
//   fifo_full      fifo_count == DEPTH
//   timeout_err    one-cycle pulse on tx_done timeout
// ---------------------------------------------------------------------------
module uart_tx_feeder #(
  parameter int DEPTH        = 16,
  parameter int GAP_CLKS     = 0,
  parameter int TIMEOUT_CLKS = 1044
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [7:0]               tx_tdata,
  output logic                     tx_tvalid,
  input  logic                     tx_busy,
  input  logic                     tx_done,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic                     timeout_err
);

  localparam int AW = $clog2(DEPTH);
  // Gap counter runs 0..GAP_CLKS-1.
  localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_GAP       = 2'd3;

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || GAP_CLKS < 0 || TIMEOUT_CLKS < 1)
  begin : g_bad_param
    $error("uart_tx_feeder: illegal parameter set");
  end

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic [7:0]    tx_tdata_q, tx_tdata_d;
  logic          tx_tvalid_q, tx_tvalid_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          push;
  logic          pop;

`ifdef UART_TX_FEEDER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout_err_q, timeout_err_d;
`endif

  // Ready depends on registered occupancy only, so a pop in the same cycle
  // never opens a slot for a push while full.
  assign s_axis_tready = (count_q != DEPTH_C);
  assign fifo_count    = count_q;
  assign fifo_empty    = (count_q == '0);
  assign fifo_full     = (count_q == DEPTH_C);
  assign tx_tdata      = tx_tdata_q;
  assign tx_tvalid     = tx_tvalid_q;

  always_comb begin
    push        = s_axis_tvalid && s_axis_tready;
    pop         = 1'b0;
    state_d     = state_q;
    tx_tdata_d  = tx_tdata_q;
    gap_cnt_d   = gap_cnt_q;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    timeout_err_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        // Pop decision uses start-of-cycle occupancy: no bypass from a push
        // landing in this same cycle.
        if (count_q != '0 && !tx_busy) begin
          pop        = 1'b1;
          tx_tdata_d = mem_q[rd_ptr_q];
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_DONE;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end
      ST_WAIT_DONE: begin
        if (tx_done) begin
          if (GAP_CLKS > 0) begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
`ifdef UART_TX_FEEDER_TIMEOUT_EN
        else if (to_cnt_q == TW'(TIMEOUT_CLKS - 1)) begin
          // Byte is considered sent; nothing is re-queued.
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      ST_GAP: begin
        if (gap_cnt_q == GW'(GAP_CLKS - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The pulse is registered out of ISSUE, giving a glitch-free single
    // cycle strobe to uart_tx while tx_tdata is already stable.
    tx_tvalid_d = (state_q == ST_ISSUE);

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_axis_tdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= ST_IDLE;
      tx_tdata_q  <= 8'h00;
      tx_tvalid_q <= 1'b0;
      gap_cnt_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      tx_tdata_q  <= tx_tdata_d;
      tx_tvalid_q <= tx_tvalid_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

`ifdef UART_TX_FEEDER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
`timescale 1ns/1ps
// Testbench for uart_tx_feeder: randomized pushes, a behavioural uart_tx
// stub, and a scoreboard monitor that checks every issued byte.
module tb_uart_tx_feeder;
  localparam int DEPTH   = 16;
  localparam int GAP     = 4;
  localparam int TO_CLKS = 50;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [7:0]    tx_tdata;
  logic          tx_tvalid;
  logic          tx_busy;
  logic          tx_done;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          timeout_err;

  logic hold_busy = 1'b0;
  logic stub_busy = 1'b0;
  logic stub_done = 1'b0;
  logic man_done  = 1'b0;
  logic stub_auto = 1'b1;

  assign tx_busy = hold_busy | stub_busy;
  assign tx_done = stub_done | man_done;

  always #5 clk = ~clk;

  uart_tx_feeder #(
    .DEPTH(DEPTH), .GAP_CLKS(GAP), .TIMEOUT_CLKS(TO_CLKS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_busy(tx_busy), .tx_done(tx_done),
    .fifo_count(fifo_count), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .timeout_err(timeout_err)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int cyc = 0;
  int tv_count = 0;
  int to_count = 0;
  int to_delta = 0;
  int last_tv_cyc = 0;
  int last_done_cyc = 0;
  bit outstanding = 0;
  bit have_done = 0;
  bit prev_tv = 0;
  bit prev_to = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural uart_tx: busy from the issue pulse until a random-length
  // frame ends with a one-cycle tx_done.
  int stub_timer = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      stub_done = 1'b0;
      if (!rst_n) begin
        stub_busy  = 1'b0;
        stub_timer = 0;
      end else if (stub_timer > 0) begin
        stub_timer--;
        if (stub_timer == 0) begin
          stub_done = 1'b1;
          stub_busy = 1'b0;
        end
      end else if (tx_tvalid && stub_auto) begin
        stub_busy  = 1'b1;
        stub_timer = $urandom_range(3, 20);
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        outstanding = 0;
        have_done   = 0;
        prev_tv     = 0;
        prev_to     = 0;
      end else begin
        check("tready_eq_not_full", s_axis_tready, !fifo_full);
        check("empty_flag", fifo_empty, fifo_count == 0);
        check("full_flag", fifo_full, fifo_count == DEPTH);
        if (tx_tvalid) begin
          check("tvalid_single_cycle", prev_tv, 0);
          check("no_issue_before_done", outstanding, 0);
          check("issue_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            check("issue_data", tx_tdata, e);
            $display("issue %0d cyc=%0d data=%02h expected=%02h", tv_count, cyc, tx_tdata, e);
          end
          if (have_done) check("issue_spacing", (cyc - last_done_cyc) >= 1 + GAP, 1);
          outstanding = 1;
          last_tv_cyc = cyc;
          tv_count++;
        end
        if (tx_done && outstanding && !tx_tvalid) begin
          outstanding   = 0;
          have_done     = 1;
          last_done_cyc = cyc;
        end
        if (timeout_err) begin
          check("timeout_single_cycle", prev_to, 0);
          to_count++;
          to_delta    = cyc - last_tv_cyc;
          outstanding = 0;
          have_done   = 0;
        end
        prev_tv = tx_tvalid;
        prev_to = timeout_err;
      end
    end
  end

  task automatic push_byte(input logic [7:0] b, input int bound, output bit ok);
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    ok = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      if (s_axis_tready) begin
        exp_q.push_back(b);
        ok = 1;
      end
      tick();
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_tv(input string name, input int n, input int bound);
    for (int i = 0; i < bound && tv_count < n; i++) tick();
    check(name, tv_count >= n, 1);
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound && (exp_q.size() != 0 || outstanding || !fifo_empty); i++) tick();
    check("drain", exp_q.size() == 0 && !outstanding && fifo_empty, 1);
    repeat (GAP + 4) tick();
  endtask

  task automatic pulse_done();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int acc, n, t;
    rst_n = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'h00;
    #2;
    check("rst_tready", s_axis_tready, 1);
    check("rst_count", fifo_count, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_tvalid", tx_tvalid, 0);
    check("rst_tdata", tx_tdata, 8'h00);
    check("rst_timeout", timeout_err, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Latency of a single byte and hold until tx_done.
    stub_auto = 1'b0;
    push_byte(8'hA5, 10, ok);
    check("lat_accept", ok, 1);
    tick();
    check("lat_edge1_tvalid", tx_tvalid, 0);
    tick();
    check("lat_edge2_tvalid", tx_tvalid, 1);
    check("lat_edge2_tdata", tx_tdata, 8'hA5);
    tick();
    check("lat_edge3_tvalid", tx_tvalid, 0);
    check("lat_tdata_hold", tx_tdata, 8'hA5);
    push_byte(8'h3C, 10, ok);
    n = tv_count;
    repeat (30) tick();
    check("hold_until_done", tv_count, n);
    pulse_done();
    wait_tv("issue_after_done", n + 1, 50);
    pulse_done();
    stub_auto = 1'b1;
    wait_drain(500);

    // Fill to full with uart_tx held busy, then pop and push offered together.
    hold_busy = 1'b1;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'($urandom);
      if (s_axis_tready) begin
        exp_q.push_back(s_axis_tdata);
        acc++;
      end
      tick();
    end
    check("fill_accepted", acc, DEPTH);
    check("fill_count", fifo_count, DEPTH);
    check("fill_full", fifo_full, 1);
    check("fill_tready", s_axis_tready, 0);
    s_axis_tdata = 8'h5A;
    hold_busy = 1'b0;
    tick();
    check("popfull_count", fifo_count, DEPTH - 1);
    check("popfull_tready", s_axis_tready, 1);
    if (s_axis_tready) exp_q.push_back(8'h5A);
    tick();
    s_axis_tvalid = 1'b0;
    check("popfull_refill_count", fifo_count, DEPTH);
    wait_drain(3000);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      push_byte(8'($urandom), 400, ok);
      check("rand_accept", ok, 1);
    end
    wait_drain(4000);
    check("rand_final_count", fifo_count, 0);

    // tx_done never arrives.
    stub_auto = 1'b0;
    n = tv_count;
    t = to_count;
    push_byte(8'hC3, 10, ok);
    push_byte(8'h96, 10, ok);
    wait_tv("to_first_issue", n + 1, 50);
`ifdef UART_TX_FEEDER_TIMEOUT_EN
    for (int i = 0; i < 200 && to_count == t; i++) tick();
    check("timeout_fired", to_count, t + 1);
    check("timeout_delay", to_delta, TO_CLKS);
    wait_tv("issue_after_timeout", n + 2, 50);
    for (int i = 0; i < 200 && to_count == t + 1; i++) tick();
    check("timeout_second", to_count, t + 2);
`else
    repeat (200) tick();
    check("no_timeout_pulse", to_count, 0);
    check("stuck_in_wait", tv_count, n + 1);
    pulse_done();
    wait_tv("issue_after_late_done", n + 2, 50);
    pulse_done();
`endif
    stub_auto = 1'b1;
    wait_drain(500);

    // Reset with bytes queued flushes them.
    hold_busy = 1'b1;
    for (int i = 0; i < 5; i++) push_byte(8'(8'h10 + i), 5, ok);
    check("queued_count", fifo_count, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_count", fifo_count, 0);
    check("midrst_tready", s_axis_tready, 1);
    check("midrst_empty", fifo_empty, 1);
    check("midrst_tvalid", tx_tvalid, 0);
    check("midrst_tdata", tx_tdata, 8'h00);
    exp_q.delete();
    n = tv_count;
    tick();
    tick();
    rst_n = 1'b1;
    hold_busy = 1'b0;
    repeat (40) tick();
    check("flushed_no_issue", tv_count, n);
    check("flushed_count", fifo_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
